sim_cycle_monitor: RTL
======================

Name: sim_cycle_monitor

Overview:
Synthesizable cycle-run monitor. It is the consuming end of the bench clock/cycle-budget scheme: the bench or host hands it a cycle limit, and the block counts enabled clock edges. It emits a periodic progress pulse and raises a sticky done flag when the budget is exhausted, and holds done until the requester acknowledges. It replaces hand-written wait/finish logic in bench tops and gives the verification wrapper a clean completion handshake.

Parameters:
CNT_W, 32, width of limit and count (unsigned)
REPORT_INTERVAL, 1000000, enabled cycles between progress pulses (>=1)
DEFAULT_LIMIT, 4194304, limit used when cfg_limit==0 (1<<22)

Ports:
clk  input  1  single clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  config request; limit offered on cfg_limit
cfg_ready  output  1  block can accept config (IDLE only)
cfg_limit  input  CNT_W  cycle budget, unsigned; 0 selects DEFAULT_LIMIT
en  input  1  count-enable (clock-gen running)
abort  input  1  stop run immediately, no done
done  output  1  budget reached, sticky until done_ack
done_ack  input  1  acknowledge, returns block to IDLE
busy  output  1  high in RUN
report  output  1  one-cycle progress pulse
count  output  CNT_W  enabled cycles counted in current run

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. During reset and after it: state=IDLE, count=0, done=0, busy=0, report=0, cfg_ready=1, internal limit=0, interval counter=0.
- All outputs are registered. cfg_ready=1 exactly when state==IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when cfg_valid&&cfg_ready at edge T.
  - At T: latch limit (cfg_limit, or DEFAULT_LIMIT if 0), count<=0, interval<=0, done<=0, state<=RUN, busy<=1, cfg_ready<=0.
- RUN, each edge:
  - abort=1: state<=IDLE, busy<=0, cfg_ready<=1. count holds, no done, no report. abort has priority over increment.
  - en=0: count, interval and state hold; report<=0.
  - en=1: count<=count+1. interval<=interval+1, wrapping to 0 at REPORT_INTERVAL. report<=1 on the edge interval wraps, otherwise 0.
  - en=1 and count+1==limit: on the same edge set done<=1, busy<=0, state<=DONE. count stops at limit. If a report boundary falls on that edge, report and done rise together.
  - Comparison is unsigned, full CNT_W. count never exceeds limit, so there is no wraparound.
- DONE:
  - done=1, count frozen, report=0. cfg_valid ignored (cfg_ready=0). en ignored. abort ignored.
  - done_ack=1: state<=IDLE, done<=0, cfg_ready<=1. count is retained until the next accepted config.
- done_ack outside DONE: no effect.
- Latency: accept at edge T with en held high → count reaches N at edge T+N. done rises at edge T+limit. The first report rises at edge T+REPORT_INTERVAL if REPORT_INTERVAL<=limit.
- report is a pulse of exactly one cycle. Back-to-back pulses occur only when REPORT_INTERVAL==1.
- Reset asserted mid-run: immediate return to reset values. No done and no report afterwards.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle → all outputs go to reset values asynchronously; after release cfg_ready=1, count=0, done=0.
- Basic run (REPORT_INTERVAL=4): cfg_limit=10 accepted at edge T, en=1 → report pulses at T+4 and T+8. done and busy change at T+10, count=10. done stays high 5 cycles until done_ack, then cfg_ready=1 and count still 10.
- Gated enable: cfg_limit=6 with en low for 3 cycles mid-run → count holds while en=0. done rises 9 edges after accept. Reports are counted on enabled cycles only.
- Coincident boundary (REPORT_INTERVAL=4): cfg_limit=8 → report and done assert on the same edge. cfg_valid pulsed in DONE is ignored.
- Default and abort: cfg_limit=0 → internal limit 4194304, check via busy still high at count=1000. Then abort=1 on the same edge as en=1 → count holds, done=0, state IDLE. A new cfg_limit=3 clears count to 0 and completes at +3 edges.
- Wide limit (CNT_W=32): cfg_limit=32'hFFFF_FFF0 with count forced near the end via a reduced-width configuration CNT_W=8, limit=255 → done at count=255, no wrap to 0.

Source files
------------

// File: rtl/sim_cycle_monitor.sv
// sim_cycle_monitor: counts enabled clock edges against a configurable cycle budget.
// A run starts on a config handshake and emits a one-cycle progress pulse every
// REPORT_INTERVAL enabled cycles. When the budget is spent it raises a sticky done
// flag, which stays high until the requester acknowledges it.
//
// Ports:
//   clk_i        clock, all state on posedge
//   rst_ni       asynchronous active-low reset
//   cfg_valid_i  config request, limit offered on cfg_limit_i
//   cfg_ready_o  high while idle (config can be accepted)
//   cfg_limit_i  cycle budget; 0 selects DEFAULT_LIMIT
//   en_i         count enable
//   abort_i      end the run at once, without done
//   done_o       budget reached, held until done_ack_i
//   done_ack_i   acknowledge done, return to idle
//   busy_o       high while running
//   report_o     one-cycle progress pulse
//   count_o      enabled cycles counted in the current run
module sim_cycle_monitor #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned REPORT_INTERVAL = 1000000,
    parameter int unsigned DEFAULT_LIMIT   = 4194304
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_limit_i,
    input  logic             en_i,
    input  logic             abort_i,
    output logic             done_o,
    input  logic             done_ack_i,
    output logic             busy_o,
    output logic             report_o,
    output logic [CNT_W-1:0] count_o
);

    // Interval counter holds 0..REPORT_INTERVAL-1; keep at least one bit.
    localparam int unsigned IntW = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;
    localparam logic [IntW-1:0]  IntLast  = IntW'(REPORT_INTERVAL - 1);
    localparam logic [CNT_W-1:0] DefLimit = CNT_W'(DEFAULT_LIMIT);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] limit_q;
    logic [IntW-1:0]  interval_q;
    logic             done_q;
    logic             busy_q;
    logic             report_q;
    logic             cfg_ready_q;

    logic [CNT_W-1:0] count_inc;
    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            count_q     <= '0;
            limit_q     <= '0;
            interval_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            report_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            // report is a pulse: cleared on every edge unless a boundary sets it
            report_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid_i) begin
                        limit_q     <= (cfg_limit_i == '0) ? DefLimit : cfg_limit_i;
                        count_q     <= '0;
                        interval_q  <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (abort_i) begin
                        // abort wins over an enabled increment; count is kept
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else if (en_i) begin
                        count_q <= count_inc;
                        if (interval_q == IntLast) begin
                            interval_q <= '0;
                            report_q   <= 1'b1;
                        end else begin
                            interval_q <= interval_q + 1'b1;
                        end
                        // count never passes limit, so equality is sufficient
                        if (count_inc == limit_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (done_ack_i) begin
                        done_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign report_o    = report_q;
    assign count_o     = count_q;

endmodule
